// File: rtl/tx_mac_sched_pkg.sv
// Shared definitions for the Tx MAC scheduler: FSM encodings, readback offsets, helpers.
package tx_mac_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Local-bus readback offsets for the status outputs
  localparam logic [3:0] RB_BUSY        = 4'h0;
  localparam logic [3:0] RB_ACTIVE_ID   = 4'h1;
  localparam logic [3:0] RB_STRAY_DONE  = 4'h2;
  localparam logic [3:0] RB_TIMEOUT_CNT = 4'h3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tx_mac_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   grant_id,
  output logic         any
);

  always_comb begin
    int k;
    k        = 0;
    grant_id = 3'd0;
    any      = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant_id = 3'(k);
      end
    end
  end

endmodule

// File: rtl/tx_mac_sched.sv
// Round-robin scheduler sharing one Tx MAC among n_req producers.
// Optional feature: TX_MAC_SCHED_TIMEOUT_EN aborts a frame stuck in WAIT.
module tx_mac_sched
  import tx_mac_sched_pkg::*;
#(
  parameter int mac_aw = 10,
  parameter int n_req  = 4,
  parameter int gap_w  = 8,
  parameter int to_w   = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [n_req-1:0]        req_valid,
  input  logic [n_req*mac_aw-1:0] req_addr,
  output logic [n_req-1:0]        req_ack,
  output logic [n_req-1:0]        req_done,
  output logic                    req_fault,
  input  logic [gap_w-1:0]        gap_cycles,
  output logic                    tx_mac_start,
  output logic [mac_aw-1:0]       buf_start_addr,
  input  logic                    tx_mac_done,
  output logic                    busy,
  output logic [2:0]              active_id,
  output logic                    stray_done,
  output logic [7:0]              timeout_count
);

  state_e              state_q, state_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [2:0]          active_id_q, active_id_d;
  logic [mac_aw-1:0]   addr_q, addr_d;
  logic                start_q, start_d;
  logic [n_req-1:0]    ack_q, ack_d;
  logic [n_req-1:0]    done_q, done_d;
  logic                fault_q, fault_d;
  logic [gap_w-1:0]    gap_cnt_q, gap_cnt_d;
  logic                stray_q, stray_d;
  logic [7:0]          tcount_q, tcount_d;
  logic [2:0]          pick_id;
  logic                pick_any;
  logic                timeout_hit;
  logic                frame_end;

  rr_pick #(.N(n_req)) u_pick (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .grant_id (pick_id),
    .any      (pick_any)
  );

`ifdef TX_MAC_SCHED_TIMEOUT_EN
  localparam logic [to_w-1:0] TO_LAST = {{(to_w-1){1'b1}}, 1'b0};
  logic [to_w-1:0] to_cnt_q, to_cnt_d;

  // Counter restarts from zero on every entry to WAIT
  always_comb to_cnt_d = (state_q == ST_WAIT) ? to_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign timeout_hit = (state_q == ST_WAIT) && !tx_mac_done && (to_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign frame_end = (state_q == ST_WAIT) && (tx_mac_done || timeout_hit);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_WAIT;
      ST_WAIT: if (frame_end) state_d = (gap_cycles == '0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_cnt_q <= gap_w'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    active_id_d = active_id_q;
    addr_d      = addr_q;
    start_d     = 1'b0;
    ack_d       = '0;
    done_d      = '0;
    fault_d     = 1'b0;
    gap_cnt_d   = gap_cnt_q;
    tcount_d    = tcount_q;
    stray_d     = stray_q | (tx_mac_done && (state_q != ST_WAIT));
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          start_d     = 1'b1;
          active_id_d = pick_id;
          rr_ptr_d    = (pick_id == 3'(n_req - 1)) ? 3'd0 : pick_id + 3'd1;
          for (int i = 0; i < n_req; i++) begin
            if (pick_id == 3'(i)) begin
              ack_d[i] = 1'b1;
              addr_d   = req_addr[i*mac_aw +: mac_aw];
            end
          end
        end
      end
      ST_WAIT: begin
        if (frame_end) begin
          for (int i = 0; i < n_req; i++) begin
            if (active_id_q == 3'(i)) done_d[i] = 1'b1;
          end
          fault_d   = timeout_hit;
          gap_cnt_d = gap_cycles;
          if (timeout_hit) tcount_d = sat_inc8(tcount_q);
        end
      end
      ST_GAP:  gap_cnt_d = gap_cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= 3'd0;
      active_id_q <= 3'd0;
      addr_q      <= '0;
      start_q     <= 1'b0;
      ack_q       <= '0;
      done_q      <= '0;
      fault_q     <= 1'b0;
      gap_cnt_q   <= '0;
      stray_q     <= 1'b0;
      tcount_q    <= 8'd0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      active_id_q <= active_id_d;
      addr_q      <= addr_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      gap_cnt_q   <= gap_cnt_d;
      stray_q     <= stray_d;
      tcount_q    <= tcount_d;
    end
  end

  assign req_ack        = ack_q;
  assign req_done       = done_q;
  assign req_fault      = fault_q;
  assign tx_mac_start   = start_q;
  assign buf_start_addr = addr_q;
  assign busy           = (state_q != ST_IDLE);
  assign active_id      = active_id_q;
  assign stray_done     = stray_q;
  assign timeout_count  = tcount_q;

endmodule

// File: tb/tb_tx_mac_sched.sv
// Directed self-checking bench for tx_mac_sched (timeout case needs TX_MAC_SCHED_TIMEOUT_EN).
module tb_tx_mac_sched;

  localparam int AW = 10;
  localparam int N  = 4;
  localparam int GW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    req_done;
  logic            req_fault;
  logic [GW-1:0]   gap_cycles;
  logic            tx_mac_start;
  logic [AW-1:0]   buf_start_addr;
  logic            tx_mac_done;
  logic            busy;
  logic [2:0]      active_id;
  logic            stray_done;
  logic [7:0]      timeout_count;

  int total = 0;
  int bad   = 0;

  tx_mac_sched #(.mac_aw(AW), .n_req(N), .gap_w(GW), .to_w(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ack        (req_ack),
    .req_done       (req_done),
    .req_fault      (req_fault),
    .gap_cycles     (gap_cycles),
    .tx_mac_start   (tx_mac_start),
    .buf_start_addr (buf_start_addr),
    .tx_mac_done    (tx_mac_done),
    .busy           (busy),
    .active_id      (active_id),
    .stray_done     (stray_done),
    .timeout_count  (timeout_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    while (!tx_mac_start && n < budget) begin
      tick;
      n++;
    end
    chk("start_seen", 32'(tx_mac_start), 32'd1);
  endtask

  task automatic frame_done;
    tx_mac_done = 1'b1;
    tick;
    tx_mac_done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   32'(req_ack), 32'd0);
    chk({tag, "_done"},  32'(req_done), 32'd0);
    chk({tag, "_fault"}, 32'(req_fault), 32'd0);
    chk({tag, "_start"}, 32'(tx_mac_start), 32'd0);
    chk({tag, "_addr"},  32'(buf_start_addr), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_id"},    32'(active_id), 32'd0);
    chk({tag, "_stray"}, 32'(stray_done), 32'd0);
    chk({tag, "_tocnt"}, 32'(timeout_count), 32'd0);
  endtask

  initial begin
    int n;
    int exp_id;
    logic seen;
    rst         = 1'b1;
    req_valid   = '0;
    req_addr    = {10'h300, 10'h200, 10'h100, 10'h000};
    gap_cycles  = '0;
    tx_mac_done = 1'b0;
    do_reset;
    chk_reset_vals("rst0");

    // Single requester with addr 0x100 on slot 0
    req_addr  = {10'h300, 10'h200, 10'h000, 10'h100};
    req_valid = 4'b0001;
    tick;
    chk("t1_start", 32'(tx_mac_start), 32'd1);
    chk("t1_addr", 32'(buf_start_addr), 32'h100);
    chk("t1_ack", 32'(req_ack), 32'b0001);
    chk("t1_busy", 32'(busy), 32'd1);
    req_valid = 4'b0000;
    tick;
    chk("t1_start_pulse", 32'(tx_mac_start), 32'd0);
    chk("t1_ack_pulse", 32'(req_ack), 32'd0);
    repeat (49) tick;
    chk("t1_done_early", 32'(req_done), 32'd0);
    frame_done;
    chk("t1_done", 32'(req_done), 32'b0001);
    chk("t1_fault", 32'(req_fault), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    tick;
    chk("t1_done_pulse", 32'(req_done), 32'd0);

    // All four held valid, no gap: strict rotation 0,1,2,3,0
    req_addr  = {10'h300, 10'h200, 10'h100, 10'h000};
    do_reset;
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_id = f % 4;
      wait_start(10, n);
      chk("t2_id", 32'(active_id), 32'(exp_id));
      chk("t2_addr", 32'(buf_start_addr), 32'(exp_id * 32'h100));
      chk("t2_ack", 32'(req_ack), 32'(1 << exp_id));
      seen = 1'b0;
      repeat (4) begin
        tick;
        seen = seen | tx_mac_start | (|req_ack);
      end
      chk("t2_no_grant_in_wait", 32'(seen), 32'd0);
      chk("t2_busy", 32'(busy), 32'd1);
      frame_done;
      chk("t2_done", 32'(req_done), 32'(1 << exp_id));
    end
    req_valid = '0;
    tick;
    tick;

    // Holdoff of 10 cycles: next start 12 cycles after the done strobe
    do_reset;
    gap_cycles = 8'd10;
    req_valid  = 4'b0011;
    wait_start(10, n);
    req_valid = 4'b0010;
    repeat (3) tick;
    frame_done;
    n = 1;
    chk("t3_gap_busy", 32'(busy), 32'd1);
    while (!tx_mac_start && n < 40) begin
      tick;
      n++;
    end
    chk("t3_spacing", 32'(n), 32'd12);
    chk("t3_id", 32'(active_id), 32'd1);
    req_valid = '0;
    tick;
    frame_done;
    repeat (3) tick;
    chk("t3_stray_before", 32'(stray_done), 32'd0);
    frame_done;
    chk("t3_stray_gap", 32'(stray_done), 32'd1);
    repeat (12) tick;
    chk("t3_stray_sticky", 32'(stray_done), 32'd1);
    gap_cycles = 8'd0;

    // Withdrawal: requester 2 drops while 1 is in WAIT
    do_reset;
    req_valid = 4'b1110;
    wait_start(10, n);
    chk("t4_first_id", 32'(active_id), 32'd1);
    req_valid = 4'b1100;
    tick;
    req_valid = 4'b1000;
    tick;
    frame_done;
    seen = 1'b0;
    n = 0;
    while (!tx_mac_start && n < 10) begin
      seen = seen | req_ack[2];
      tick;
      n++;
    end
    chk("t4_start_seen", 32'(tx_mac_start), 32'd1);
    chk("t4_no_ack2", 32'(seen | req_ack[2]), 32'd0);
    chk("t4_next_id", 32'(active_id), 32'd3);
    chk("t4_ack3", 32'(req_ack), 32'b1000);
    req_valid = '0;
    tick;
    frame_done;

`ifdef TX_MAC_SCHED_TIMEOUT_EN
    // Timeout after 63 WAIT cycles
    do_reset;
    req_valid = 4'b0001;
    wait_start(10, n);
    req_valid = '0;
    n = 0;
    while (!req_done[0] && n < 200) begin
      tick;
      n++;
    end
    chk("t5_to_cycles", 32'(n), 32'd63);
    chk("t5_to_done", 32'(req_done), 32'b0001);
    chk("t5_to_fault", 32'(req_fault), 32'd1);
    chk("t5_to_count", 32'(timeout_count), 32'd1);
    chk("t5_to_idle", 32'(busy), 32'd0);
    tick;
    frame_done;
    chk("t5_stray_idle", 32'(stray_done), 32'd1);
`else
    // Without the timeout, WAIT holds indefinitely
    do_reset;
    req_valid = 4'b0001;
    wait_start(10, n);
    req_valid = '0;
    seen = 1'b0;
    repeat (80) begin
      tick;
      seen = seen | (|req_done) | req_fault;
    end
    chk("t5_no_abort", 32'(seen), 32'd0);
    chk("t5_still_busy", 32'(busy), 32'd1);
    chk("t5_tocnt", 32'(timeout_count), 32'd0);
    frame_done;
    chk("t5_done", 32'(req_done), 32'b0001);
    chk("t5_fault", 32'(req_fault), 32'd0);
    tick;
    frame_done;
    chk("t5_stray_idle", 32'(stray_done), 32'd1);
`endif

    // Reset mid-frame: outputs return to reset values, pointer back to 0
    do_reset;
    req_valid = 4'b1111;
    wait_start(10, n);
    tick;
    frame_done;
    wait_start(10, n);
    chk("t6_id1", 32'(active_id), 32'd1);
    tick;
    frame_done;
    chk("t6_stray_set", 32'(stray_done), 32'd0);
    frame_done;
    wait_start(10, n);
    chk("t6_id2", 32'(active_id), 32'd2);
    tick;
    rst = 1'b1;
    tick;
    chk_reset_vals("t6_rst");
    rst = 1'b0;
    wait_start(10, n);
    chk("t6_after_rst_id", 32'(active_id), 32'd0);
    chk("t6_after_rst_ack", 32'(req_ack), 32'b0001);
    req_valid = '0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t6_no_done_abort", 32'(req_done), 32'd0);
    frame_done;
    chk("t6_late_stray", 32'(stray_done), 32'd1);
    chk("t6_late_no_done", 32'(req_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_mac_sched.md
# tx_mac_sched

Round-robin scheduler that shares the single Tx MAC engine among up to `n_req` packet producers: local-bus host, mailbox responder, and future soft-core or diagnostic sources. Each requester owns a region of the Tx MAC DPRAM and posts a frame start address. The scheduler issues `tx_mac_start`/`buf_start_addr` to the Tx MAC, waits for `tx_mac_done`, enforces an inter-frame holdoff, and reports completion per requester. It sits between the requesters and the `rtefi_blob` Tx MAC ports, entirely in the `tx_clk` (== `lb_clk`) domain.

## Interface
Parameters:
- `mac_aw`, 10: Tx MAC buffer address width.
- `n_req`, 4: number of requesters (2..8).
- `gap_w`, 8: width of the holdoff counter.
- `to_w`, 20: timeout counter width (used only with `TX_MAC_SCHED_TIMEOUT_EN`).

Ports:
- `clk`  in  1: Tx/local-bus clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  n_req: frame pending per requester. Must be held until `req_ack`.
- `req_addr`  in  n_req*mac_aw: start address, requester i at `[i*mac_aw +: mac_aw]`.
- `req_ack`  out  n_req: one-cycle pulse when the request is granted.
- `req_done`  out  n_req: one-cycle pulse when the granted frame finishes or is aborted.
- `req_fault`  out  1: qualifies `req_done`; high for timeout abort.
- `gap_cycles`  in  gap_w: holdoff after each frame, in cycles; static during operation.
- `tx_mac_start`  out  1: one-cycle start strobe to the Tx MAC.
- `buf_start_addr`  out  mac_aw: frame address, valid from the start strobe until done.
- `tx_mac_done`  in  1: one-cycle completion strobe from the Tx MAC.
- `busy`  out  1: high in any state other than IDLE.
- `active_id`  out  3: index of the current or last grant.
- `stray_done`  out  1: sticky flag, set when `tx_mac_done` arrives outside WAIT. Cleared by `rst` only.
- `timeout_count`  out  8: saturating count of timeout aborts.

## Operation
- States: IDLE, WAIT, GAP.
- **IDLE**
  - If `|req_valid`, the rr picker chooses the first set bit at or after `rr_ptr`, wrapping modulo `n_req`.
  - Registered on that edge: `buf_start_addr` = the winner's address, `active_id` = winner, `rr_ptr` = (winner+1) mod n_req.
  - `tx_mac_start` and `req_ack[winner]` pulse for one cycle, and the state moves to WAIT.
- **WAIT**
  - On `tx_mac_done`: pulse `req_done[active_id]` with `req_fault`=0.
  - Then go to GAP with `gap_cnt` = `gap_cycles`, or straight to IDLE if `gap_cycles` is 0.
- **GAP**
  - Decrement `gap_cnt` each cycle. When it reaches 1, go to IDLE.
  - Requests remain pending while in GAP and are not granted.
- Requesters may drop `req_valid` before ack (withdraw); the scheduler never grants a withdrawn request.
- A `tx_mac_done` arriving in the same cycle as a new grant is impossible by construction: start only occurs from IDLE. Any `tx_mac_done` seen in IDLE or GAP sets `stray_done` and is otherwise ignored.
- Simultaneous requests: exactly one grant per frame. Fairness guarantees each continuously-valid requester is granted within `n_req` frames.
- `rst` mid-frame:
  - State goes to IDLE and `rr_ptr` to 0.
  - All outputs take their reset values.
  - No `req_done` is issued for the aborted frame.
  - Any late `tx_mac_done` after reset sets `stray_done`.

## Timing
- Reset values: `req_ack`=0, `req_done`=0, `req_fault`=0, `tx_mac_start`=0, `buf_start_addr`=0, `busy`=0, `active_id`=0, `stray_done`=0, `timeout_count`=0.
- Grant latency: `tx_mac_start` is asserted the cycle after `req_valid` is first sampled high in IDLE.
- `req_done` is asserted the cycle after `tx_mac_done` is sampled.
- Minimum spacing between start strobes: (frame time) + 1 + `gap_cycles` clocks.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Configuration
- `TX_MAC_SCHED_TIMEOUT_EN` defined:
  - A `to_w`-bit counter runs in WAIT.
  - At 2^to_w−1 cycles without `tx_mac_done`, the scheduler pulses `req_done[active_id]` with `req_fault`=1, increments `timeout_count` (saturating at 255), and enters GAP.
- Undefined: WAIT lasts indefinitely, `req_fault` is tied 0, and `timeout_count` is tied 0.

## Structure
- Shared package `tx_mac_sched_pkg`: state encodings (IDLE=0, WAIT=1, GAP=2) and the local-bus readback offsets for `busy`, `active_id`, `stray_done` and `timeout_count`.
- One sub-module, `rr_pick`: combinational round-robin priority picker with inputs `req`[n_req] and `ptr`, and outputs `grant_id` and `any`. Reused by future arbiters.

## Test plan
- Single requester: `req_valid[0]`=1, addr 0x100 → `tx_mac_start` one cycle later with `buf_start_addr`=0x100 and `req_ack[0]`. Drive `tx_mac_done` 50 cycles later → `req_done[0]` the next cycle, `req_fault`=0.
- All four requesters held valid, addrs 0x000/0x100/0x200/0x300, `gap_cycles`=0 → grants in order 0,1,2,3,0. No grant is issued while `busy` and in WAIT.
- `gap_cycles`=10, two back-to-back requests → the second `tx_mac_start` comes exactly 12 cycles after the first `tx_mac_done`.
- Withdrawal: `req_valid[2]` drops while request 1 is in WAIT → no `req_ack[2]`, and the next grant goes to requester 3.
- Timeout (macro on, `to_w`=6), no `tx_mac_done` → `req_done` with `req_fault`=1 after 63 WAIT cycles, `timeout_count`=1. Then inject `tx_mac_done` in IDLE → `stray_done`=1.
- Assert `rst` during WAIT → all outputs return to their reset values the next cycle, and the next grant goes to requester 0.
